// File: rtl/display_arbiter.sv
// Two-port arbiter for the shared 3-digit display: captures a binary value from the
// granted port, converts it to BCD with a sequential double-dabble, then holds it.
module display_arbiter #(
    parameter int HOLD_CNT = 50000,
    parameter int DATA_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    output logic [3:0]        digit0,
    output logic [3:0]        digit1,
    output logic [3:0]        digit2,
    output logic              overflow,
    output logic              src,
    output logic              busy
);

    localparam int ITER_W = $clog2(DATA_W + 1);
    localparam int HOLD_W = (HOLD_CNT > 1) ? $clog2(HOLD_CNT) : 1;
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DATA_W);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CNT - 1);
    localparam logic [DATA_W-1:0] MAX_SHOWN = DATA_W'(999);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   bin_q, bin_d;
    logic [11:0]         bcd_q, bcd_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                last_q, last_d;
    logic                sel_q, sel_d;
    logic                ovf_cap_q, ovf_cap_d;
    logic [3:0]          digit0_q, digit0_d;
    logic [3:0]          digit1_q, digit1_d;
    logic [3:0]          digit2_q, digit2_d;
    logic                overflow_q, overflow_d;
    logic                src_q, src_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                busy_q, busy_d;

    logic                gnt_port;
    logic [DATA_W-1:0]   gnt_data;
    logic [11:0]         bcd_adj;

    // Add-3 correction of every BCD nibble that is 5 or more, ahead of the shift.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        (bcd_q[gi*4 +: 4] + 4'd3) : bcd_q[gi*4 +: 4];
        end
    endgenerate

    // Contention goes to the port that was not served last; a lone request wins outright.
    assign gnt_port = (req0 && req1) ? ~last_q : req1;
    assign gnt_data = gnt_port ? data1 : data0;

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        hold_d     = hold_q;
        last_d     = last_q;
        sel_d      = sel_q;
        ovf_cap_d  = ovf_cap_q;
        digit0_d   = digit0_q;
        digit1_d   = digit1_q;
        digit2_d   = digit2_q;
        overflow_d = overflow_q;
        src_d      = src_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    bin_d     = gnt_data;
                    bcd_d     = '0;
                    iter_d    = '0;
                    ovf_cap_d = (gnt_data > MAX_SHOWN);
                    last_d    = gnt_port;
                    sel_d     = gnt_port;
                    ack0_d    = ~gnt_port;
                    ack1_d    = gnt_port;
                    state_d   = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (iter_q == ITER_LAST) begin
                    // Outputs change only here, so partial results are never visible.
                    digit0_d   = ovf_cap_q ? 4'd9 : bcd_q[3:0];
                    digit1_d   = ovf_cap_q ? 4'd9 : bcd_q[7:4];
                    digit2_d   = ovf_cap_q ? 4'd9 : bcd_q[11:8];
                    overflow_d = ovf_cap_q;
                    src_d      = sel_q;
                    hold_d     = '0;
                    state_d    = ST_HOLD;
                end else begin
                    bcd_d  = {bcd_adj[10:0], bin_q[DATA_W-1]};
                    bin_d  = {bin_q[DATA_W-2:0], 1'b0};
                    iter_d = iter_q + ITER_W'(1);
                end
            end
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            hold_q     <= '0;
            last_q     <= 1'b0;
            sel_q      <= 1'b0;
            ovf_cap_q  <= 1'b0;
            digit0_q   <= '0;
            digit1_q   <= '0;
            digit2_q   <= '0;
            overflow_q <= 1'b0;
            src_q      <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            iter_q     <= iter_d;
            hold_q     <= hold_d;
            last_q     <= last_d;
            sel_q      <= sel_d;
            ovf_cap_q  <= ovf_cap_d;
            digit0_q   <= digit0_d;
            digit1_q   <= digit1_d;
            digit2_q   <= digit2_d;
            overflow_q <= overflow_d;
            src_q      <= src_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            busy_q     <= busy_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign digit0   = digit0_q;
    assign digit1   = digit1_q;
    assign digit2   = digit2_q;
    assign overflow = overflow_q;
    assign src      = src_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Randomised scoreboard bench for display_arbiter: a timing-level reference model
// predicts grants, acks and display contents; a monitor compares every cycle.
module tb_display_arbiter;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst;
    logic       req0, req1;
    logic [9:0] data0, data1;
    logic       ack0, ack1;
    logic [3:0] digit0, digit1, digit2;
    logic       overflow, src, busy;

    display_arbiter #(.HOLD_CNT(HOLD), .DATA_W(10)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .digit0(digit0), .digit1(digit1), .digit2(digit2),
        .overflow(overflow), .src(src), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int at;
        int port;
        int value;
        int disp;
    } exp_t;

    exp_t ackq[$];
    exp_t dispq[$];

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;
    bit armed    = 1'b0;
    int m_last   = 0;
    int m_free   = 0;
    int m_busy_until = -1;
    int cur_disp = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 'h%0h expected 'h%0h (edge %0d)", name, got, exp, edge_n);
    endtask

    // Reference model: a grant is possible once the previous one is 12+HOLD edges old.
    initial begin
        int g, v, s;
        exp_t e;
        forever begin
            @(posedge clk);
            edge_n++;
            if (rst) begin
                armed = 1'b1;
                ackq.delete();
                dispq.delete();
                m_last = 0;
                m_free = edge_n + 1;
                m_busy_until = edge_n - 1;
                cur_disp = 0;
            end else if (armed && edge_n >= m_free && (req0 || req1)) begin
                if (req0 && req1) g = 1 - m_last;
                else g = req1 ? 1 : 0;
                v = (g == 1) ? int'(data1) : int'(data0);
                s = (v > 999) ? 999 : v;
                e.at = edge_n;
                e.port = g;
                e.value = v;
                e.disp = ((v > 999) ? 1 : 0) * 8192 + g * 4096
                       + (s / 100) * 256 + ((s / 10) % 10) * 16 + (s % 10);
                ackq.push_back(e);
                e.at = edge_n + 11;
                dispq.push_back(e);
                m_last = g;
                m_free = edge_n + 12 + HOLD;
                m_busy_until = edge_n + 10 + HOLD;
            end
        end
    end

    // Monitor: samples outputs on the falling edge and pops due expectations.
    initial begin
        int exp_ack;
        forever begin
            @(negedge clk);
            if (armed) begin
                exp_ack = 0;
                if (ackq.size() > 0 && ackq[0].at == edge_n) begin
                    exp_ack = (ackq[0].port == 1) ? 2 : 1;
                    void'(ackq.pop_front());
                end
                chk("ack", int'({ack1, ack0}), exp_ack);
                if (dispq.size() > 0 && dispq[0].at == edge_n) begin
                    cur_disp = dispq[0].disp;
                    $display("edge %0d: port %0d value %0d -> display %0h ovf %0d",
                             edge_n, dispq[0].port, dispq[0].value, cur_disp % 4096, cur_disp / 8192);
                    void'(dispq.pop_front());
                end
                chk("display", int'({overflow, src, digit2, digit1, digit0}), cur_disp);
                chk("busy", int'(busy), (edge_n <= m_busy_until) ? 1 : 0);
            end
        end
    end

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            rst   = 1'b1;
            req0  = 1'($urandom_range(0, 1));
            req1  = 1'($urandom_range(0, 1));
            data0 = 10'($urandom_range(0, 1023));
            data1 = 10'($urandom_range(0, 1023));
            @(negedge clk);
        end
        rst  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic wait_ack(input int port);
        int seen = 0;
        for (int i = 0; i < 60 && seen == 0; i++) begin
            @(negedge clk);
            if ((port == 1) ? ack1 : ack0) seen = 1;
        end
        if (port == 1) req1 = 1'b0;
        else req0 = 1'b0;
        chk("ack_wait", seen, 1);
    endtask

    task automatic raise(input int port, input int val);
        if (port == 1) begin data1 = 10'(val); req1 = 1'b1; end
        else begin data0 = 10'(val); req0 = 1'b1; end
    endtask

    task automatic single(input int port, input int val);
        raise(port, val);
        wait_ack(port);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        do_reset(2);
        repeat (2) @(negedge clk);

        single(0, 123);
        single(0, 0);
        single(0, 999);
        single(0, 1000);
        single(0, 1023);

        do_reset(2);
        raise(0, 7);
        raise(1, 450);
        repeat (3 * (12 + HOLD) + 4) @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (20) @(negedge clk);

        raise(0, 5);
        wait_ack(0);
        repeat (13) @(negedge clk);
        raise(1, 88);
        wait_ack(1);
        repeat (20) @(negedge clk);

        raise(0, 321);
        wait_ack(0);
        repeat (4) @(negedge clk);
        do_reset(1);
        repeat (3) @(negedge clk);
        single(1, 654);

        for (int c = 0; c < 900; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset(1);
            end else begin
                if (!req0) begin
                    if ($urandom_range(0, 7) == 0) raise(0, int'($urandom_range(0, 1023)));
                    else data0 = 10'($urandom_range(0, 1023));
                end else if ($urandom_range(0, 15) == 0) begin
                    req0 = 1'b0;
                end
                if (!req1) begin
                    if ($urandom_range(0, 7) == 0) raise(1, int'($urandom_range(0, 1023)));
                    else data1 = 10'($urandom_range(0, 1023));
                end else if ($urandom_range(0, 15) == 0) begin
                    req1 = 1'b0;
                end
                @(negedge clk);
            end
        end

        req0 = 1'b0;
        req1 = 1'b0;
        repeat (40) @(negedge clk);
        chk("drain", ackq.size() + dispq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the 3-digit multiplexed 7-segment display between two requesters: port 0 (operand entry) and port 1 (result).
- Captures a 10-bit binary value from the granted requester and converts it to three BCD digits with an iterative, sequential double-dabble.
- Presents the digits, stable, to the display multiplexer and holds them for a minimum time before it re-arbitrates.
- Sits between the datapath/keypad logic and the display multiplexer.

Parameters:
- HOLD_CNT, default 50000: minimum number of cycles a converted value stays displayed before the next arbitration. Legal values are 1 or greater.
- DATA_W, default 10: width of the binary input values. Fixed at 10 in this revision; the conversion iteration count equals DATA_W.

Ports:
- clk, input, 1: system clock. All logic is on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- req0, input, 1: port 0 request, level-sensitive.
- data0, input, 10: port 0 binary value. Must be stable while req0 is high.
- ack0, output, 1: one-cycle pulse when data0 is captured.
- req1, input, 1: port 1 request, level-sensitive.
- data1, input, 10: port 1 binary value. Must be stable while req1 is high.
- ack1, output, 1: one-cycle pulse when data1 is captured.
- digit0, output, 4: BCD units digit, for the rightmost display.
- digit1, output, 4: BCD tens digit.
- digit2, output, 4: BCD hundreds digit.
- overflow, output, 1: the displayed value was clamped.
- src, output, 1: port that owns the current display content.
- busy, output, 1: high whenever the state is not IDLE.

Behaviour:
- Reset (rst sampled high at a clock edge):
  - State goes to IDLE.
  - digit0, digit1, digit2 = 0.
  - overflow = 0, src = 0, ack0 = 0, ack1 = 0, busy = 0.
  - Hold counter = 0; round-robin pointer last = 0, so port 1 is favoured first.
  - Reset has priority over every other event in every state. It aborts CONVERT or HOLD with no ack and no partial digit update.
- Registered outputs: all outputs are registered, with no combinational path from inputs to outputs.
- FSM: IDLE -> CONVERT -> HOLD -> IDLE.
- IDLE (arbitration):
  - Only req1 high: grant port 1.
  - Only req0 high: grant port 0.
  - Both high: grant the port not equal to last.
  - Neither high: stay in IDLE.
- On a grant at edge E0:
  - Capture the granted data into the binary shift register and clear the 12-bit BCD register.
  - Pulse ack of the granted port high for exactly the cycle after E0; the other ack stays 0.
  - Set last = granted port.
  - Go to CONVERT.
- CONVERT:
  - Edges E1..E10 perform one double-dabble iteration each: add 3 to any BCD nibble ≥ 5, then shift left by one with the binary MSB entering the BCD LSB.
  - Iteration count = DATA_W = 10.
  - At edge E11 load digit0/1/2, overflow and src atomically, clear the hold counter, and go to HOLD.
  - Digit outputs never show intermediate conversion values.
  - Capture-to-display latency is fixed at 11 cycles, independent of the value.
- Overflow: if the captured value is > 999, digits load 9,9,9 (digit0, digit1, digit2) and overflow = 1 at E11. Otherwise overflow = 0. Latency is unchanged.
- HOLD:
  - The hold counter increments every cycle.
  - When counter == HOLD_CNT-1, go to IDLE at the next edge. HOLD therefore lasts exactly HOLD_CNT cycles.
  - Requests are ignored and no ack is issued.
  - Digits, overflow and src stay constant.
- Held requests:
  - A request that stays high is served again on the next IDLE visit, giving a periodic refresh. It is re-captured with a fresh ack each time.
  - A requester wanting a single capture deasserts req in the cycle ack is seen.
- busy = 1 in CONVERT and HOLD, 0 in IDLE.
- Minimum turnaround: grant-to-next-grant is 12 + HOLD_CNT cycles. This is one IDLE cycle, 11 conversion edges and HOLD_CNT hold cycles.
- Inputs with X on a non-requesting port must not affect outputs.

Test Plan:
- Reset: assert rst for 2 cycles with random reqs/data -> all outputs 0, no ack pulses, busy = 0.
- Single request: req0 = 1, data0 = 123, HOLD_CNT = 4 -> ack0 high for exactly 1 cycle, ack1 = 0, busy rises; 11 cycles after the capture edge the digits read 3,2,1 with src = 0 and overflow = 0; busy falls 4 cycles later.
- Boundaries: data0 = 0 -> 0,0,0; data0 = 999 -> 9,9,9 with overflow = 0; data0 = 1000 and 1023 -> 9,9,9 with overflow = 1.
- Contention after reset: req0 = 1 with data0 = 7 and req1 = 1 with data1 = 450, both held -> port 1 granted first with digits 0,5,4 and src = 1. Next grant goes to port 0 with digits 7,0,0 and src = 0, then back to port 1. Grants are spaced exactly 12 + HOLD_CNT cycles apart.
- Request during HOLD: raise req1 mid-HOLD while port 0 owns the display -> no ack until the first IDLE cycle, and digits unchanged until that conversion completes.
- Reset mid-CONVERT: assert rst at iteration 5 of converting 321 -> digits remain 0 from reset, no further ack, and state IDLE. A new request after reset converts correctly.
